// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction-fetch stage: owns the fetch PC, reads the instruction memory
//   combinationally and buffers {pc, instr, pred} entries in a DEPTH-entry
//   FIFO that decode drains through a valid/ready handshake.
//   A redirect flushes the queue and restarts fetch at the word-aligned target.
//
//   Optional feature macro: FETCH_BTFN_PREDICT_EN
//     defined   -> static backward-taken / forward-not-taken prediction on
//                  conditional branches (the entry's pred bit records it)
//     undefined -> sequential fetch only, id_pred_taken tied 0
//
//   Handshake: an entry moves to decode on any rising edge where
//   id_valid && id_ready. id_valid never depends on id_ready, and the head
//   entry (id_pc/id_instr/id_pred_taken) stays stable until it is accepted
//   or a redirect/reset flushes the queue.
module fetch_queue_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [XLEN-1:0]         imem_addr,
  output logic                    imem_en,
  input  logic [31:0]             imem_rdata,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic                    id_valid,
  input  logic                    id_ready,
  output logic [XLEN-1:0]         id_pc,
  output logic [31:0]             id_instr,
  output logic                    id_pred_taken,
  output logic [$clog2(DEPTH):0]  q_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0]    NOP_INSTR  = 32'h0000_0013;
  localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

  // Fetch state and queue bookkeeping
  logic [XLEN-1:0] r_fetch_pc;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  // Queue storage (contents need no reset; they are only visible when count!=0)
  logic [XLEN-1:0] r_q_pc    [DEPTH];
  logic [31:0]     r_q_instr [DEPTH];

  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_enq;
  logic [XLEN-1:0] w_next_pc;
  logic            w_unused_redirect_lsbs;

  // The redirect target is forced word-aligned, so its two low bits are dropped
  assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);

  // Redirect squashes the presented head, so decode can never consume it
  assign id_valid = !w_empty && !redirect_valid;
  assign w_pop    = id_valid && id_ready;

  // A full queue may still accept a fetch in the cycle its head leaves.
  // Reset gates the strobe so it reads 0 immediately on async assertion.
  assign imem_en   = !reset && !redirect_valid && (!w_full || w_pop);
  assign w_enq     = imem_en;
  assign imem_addr = r_fetch_pc;
  assign q_count   = r_count;

  // Head entry is presented combinationally; an empty queue shows a NOP
  assign id_pc    = w_empty ? '0 : r_q_pc[r_rd_ptr];
  assign id_instr = w_empty ? NOP_INSTR : r_q_instr[r_rd_ptr];

`ifdef FETCH_BTFN_PREDICT_EN
  logic            r_q_pred [DEPTH];
  logic            w_bwd_branch;
  logic [XLEN-1:0] w_br_offset;

  // Conditional branch with a negative offset is predicted taken
  assign w_bwd_branch = (imem_rdata[6:0] == 7'b1100011) && imem_rdata[31];
  assign w_br_offset  = {{(XLEN-12){imem_rdata[31]}}, imem_rdata[7],
                         imem_rdata[30:25], imem_rdata[11:8], 1'b0};
  assign w_next_pc    = w_bwd_branch ? (r_fetch_pc + w_br_offset)
                                     : (r_fetch_pc + XLEN'(4));
  assign id_pred_taken = w_empty ? 1'b0 : r_q_pred[r_rd_ptr];

  // Record the prediction alongside the fetched entry
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_pred[r_wr_ptr] <= w_bwd_branch;
    end
  end
`else
  assign w_next_pc     = r_fetch_pc + XLEN'(4);
  assign id_pred_taken = 1'b0;
`endif

  // Write the fetched {pc, instr} pair into the tail slot
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_pc[r_wr_ptr]    <= r_fetch_pc;
      r_q_instr[r_wr_ptr] <= imem_rdata;
    end
  end

  // Fetch PC, pointers and occupancy; redirect overrides enqueue and pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_enq) begin
        r_fetch_pc <= w_next_pc;
        r_wr_ptr   <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
//   Bench for fetch_queue_unit (XLEN=64, DEPTH=4, RESET_PC=0).
//   The instruction memory returns an address-derived ALU word everywhere
//   except 0x40, which holds a backward beq (0xFE000EE3).
//   Honours FETCH_BTFN_PREDICT_EN the same way the design does.
module tb_fetch_queue_unit;

  localparam int          XLEN  = 64;
  localparam int          DEPTH = 4;
  localparam logic [63:0] RST_PC = 64'h0;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [63:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        id_pred_taken;
  logic [2:0]  q_count;

  fetch_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_pred_taken  (id_pred_taken),
    .q_count        (q_count)
  );

  // ---------------- instruction memory ----------------
  function automatic logic [31:0] imem_word(input logic [63:0] a);
    if (a == 64'h40) return 32'hFE00_0EE3;
    return {a[21:2], 12'h013};
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  function automatic logic exp_pred(input logic [31:0] w);
`ifdef FETCH_BTFN_PREDICT_EN
    return (w[6:0] == 7'b1100011) && w[31];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] exp_next(input logic [63:0] pc, input logic [31:0] w);
    logic [63:0] off;
    off = {{52{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    if (exp_pred(w)) return pc + off;
    return pc + 64'd4;
  endfunction

  // ---------------- scoreboard ----------------
  // entry = {pc[96:33], instr[32:1], pred[0]}
  logic [96:0] exp_q[$];
  logic [63:0] m_pc = RST_PC;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc = RST_PC;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_addr"},   imem_addr, RST_PC);
    check_eq({tag, "_en"},     64'(imem_en), 64'd0);
    check_eq({tag, "_valid"},  64'(id_valid), 64'd0);
    check_eq({tag, "_pc"},     id_pc, 64'd0);
    check_eq({tag, "_instr"},  64'(id_instr), 64'(NOP));
    check_eq({tag, "_pred"},   64'(id_pred_taken), 64'd0);
    check_eq({tag, "_count"},  64'(q_count), 64'd0);
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model
  task automatic step(input logic redir, input logic [63:0] rpc, input logic rdy);
    logic        m_idv, m_pop, m_en;
    logic [96:0] head;
    logic [31:0] w;
    redirect_valid = redir;
    redirect_pc    = rpc;
    id_ready       = rdy;
    @(negedge clk);
    m_idv = !reset && (exp_q.size() != 0) && !redir;
    m_pop = m_idv && rdy;
    m_en  = !reset && !redir && ((exp_q.size() != DEPTH) || m_pop);
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("imem_en",   64'(imem_en), 64'(m_en));
    check_eq("id_valid",  64'(id_valid), 64'(m_idv));
    check_eq("q_count",   64'(q_count), 64'(exp_q.size()));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check_eq("id_pc",    id_pc, head[96:33]);
      check_eq("id_instr", 64'(id_instr), 64'(head[32:1]));
      check_eq("id_pred",  64'(id_pred_taken), 64'(head[0]));
    end else begin
      check_eq("id_pc_empty",    id_pc, 64'd0);
      check_eq("id_instr_empty", 64'(id_instr), 64'(NOP));
      check_eq("id_pred_empty",  64'(id_pred_taken), 64'd0);
    end
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else if (redir) begin
      exp_q.delete();
      m_pc = {rpc[63:2], 2'b00};
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_en) begin
        w = imem_word(m_pc);
        exp_q.push_back({m_pc, w, exp_pred(w)});
        m_pc = exp_next(m_pc, w);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    step(1'b0, 64'd0, 1'b1);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] exp_addr;
    logic        exp_p;

    // Reset state
    #1;
    check_reset_outputs("rst");
    step(1'b0, 64'd0, 1'b1);
    reset = 1'b0;

    // Streaming fetch with decode always ready
    step(1'b0, 64'd0, 1'b1);
    check_eq("t1_first_valid", 64'(id_valid), 64'd1);
    check_eq("t1_first_pc",    id_pc, 64'd0);
    for (int i = 0; i < 30; i++) step(1'b0, 64'd0, 1'b1);

    // Decode stall fills the queue, then drains without gaps
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 64'd0, 1'b0);
    check_eq("t2_addr_hold", imem_addr, 64'h10);
    check_eq("t2_count_full", 64'(q_count), 64'd4);
    check_eq("t2_en_low", 64'(imem_en), 64'd0);
    for (int i = 0; i < 12; i++) step(1'b0, 64'd0, 1'b1);
    check_eq("t3_count_steady", 64'(q_count), 64'd4);

    // Redirect to an unaligned target while three entries are queued
    step(1'b1, 64'h100, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b0);
    check_eq("t4_count3", 64'(q_count), 64'd3);
    step(1'b1, 64'h203, 1'b1);
    check_eq("t4_count0", 64'(q_count), 64'd0);
    check_eq("t4_addr",   imem_addr, 64'h200);
    step(1'b0, 64'd0, 1'b1);
    check_eq("t4_head_pc", id_pc, 64'h200);
    check_eq("t4_head_valid", 64'(id_valid), 64'd1);

    // Backward branch at 0x40
    step(1'b1, 64'h40, 1'b0);
    step(1'b0, 64'd0, 1'b0);
`ifdef FETCH_BTFN_PREDICT_EN
    exp_addr = 64'h3C;
    exp_p    = 1'b1;
`else
    exp_addr = 64'h44;
    exp_p    = 1'b0;
`endif
    check_eq("t6_next_addr", imem_addr, exp_addr);
    check_eq("t6_pred", 64'(id_pred_taken), 64'(exp_p));
    check_eq("t6_pc", id_pc, 64'h40);
    for (int i = 0; i < 6; i++) step(1'b0, 64'd0, 1'b1);

    // Fetch PC wraps silently at the top of the address space
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    check_eq("wrap_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 64'd0, 1'b1);
    check_eq("wrap_addr_zero", imem_addr, 64'd0);
    step(1'b0, 64'd0, 1'b1);

    // Asynchronous reset between edges with two entries queued
    step(1'b1, 64'h80, 1'b0);
    step(1'b0, 64'd0, 1'b0);
    step(1'b0, 64'd0, 1'b0);
    check_eq("t5_count2", 64'(q_count), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("t5_async");
    model_reset();
    step(1'b0, 64'd0, 1'b1);
    reset = 1'b0;
    step(1'b0, 64'd0, 1'b1);
    check_eq("t5_restart_pc", id_pc, RST_PC);
    for (int i = 0; i < 4; i++) step(1'b0, 64'd0, 1'b1);

    // Random decode back-pressure and redirects
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 15) == 0),
           64'($urandom_range(0, 1023)),
           ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
